// File: rtl/moving_average_filter.sv
// moving_average_filter: sliding-window averager over the last 2**LOG2_DEPTH
// unsigned samples. A circular buffer holds the window and a running sum is
// kept exact with one subtract (oldest sample) and one add (new sample) per
// accepted input. Results are presented behind a valid/ready handshake.
// Optional build macro: MOVING_AVERAGE_ROUND_EN selects round-half-up for the
// average instead of plain truncation; out_sum is the same in both builds.
module moving_average_filter #(
   parameter int DATA_W = 8,
   parameter int LOG2_DEPTH = 3,
   localparam int SUM_W = DATA_W + LOG2_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SUM_W-1:0]  out_sum,
   output logic              window_full
);

   localparam int DEPTH = 2 ** LOG2_DEPTH;
   // A depth-1 window still needs a one-bit pointer; it simply never moves.
   localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
   localparam int CNT_W = LOG2_DEPTH + 1;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_next;

   logic [PTR_W-1:0]  wp, wp_next;
   logic [CNT_W-1:0]  count, count_next;
   logic [SUM_W-1:0]  sum, sum_next;
   logic              out_valid_next;
   logic [DATA_W-1:0] oldest;
   logic              accept;
   logic              consume;

   logic [DATA_W-1:0] window_mem [DEPTH];

   // The output register can take a new result whenever it is empty or being drained.
   assign in_ready = !out_valid || out_ready;
   // clear wins over an offered sample: that sample is dropped, not accepted.
   assign accept   = in_valid && in_ready && !clear;
   assign consume  = out_valid && out_ready;

   // Next-state and datapath update: FILL only adds, RUN retires the oldest sample as well.
   always_comb begin
      state_next     = state;
      wp_next        = wp;
      count_next     = count;
      sum_next       = sum;
      out_valid_next = out_valid;
      oldest         = '0;

      if (clear) begin
         state_next     = FILL;
         wp_next        = '0;
         count_next     = '0;
         sum_next       = '0;
         out_valid_next = 1'b0;
      end else if (accept) begin
         out_valid_next = 1'b1;
         wp_next        = (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + 1'b1;
         unique case (state)
            FILL: begin
               count_next = count + 1'b1;
               if (count_next == CNT_W'(DEPTH)) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               oldest = window_mem[wp];
            end
            default: begin
               state_next = FILL;
            end
         endcase
         // The oldest sample is already part of sum, so the subtraction never underflows.
         sum_next = sum - SUM_W'(oldest) + SUM_W'(in_data);
      end else if (consume) begin
         out_valid_next = 1'b0;
      end
   end

   // State, pointer, count, running sum and result-valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         wp        <= '0;
         count     <= '0;
         sum       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         wp        <= wp_next;
         count     <= count_next;
         sum       <= sum_next;
         out_valid <= out_valid_next;
      end
   end

   // Window storage has no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (accept) begin
         window_mem[wp] <= in_data;
      end
   end

   assign out_sum     = sum;
   assign window_full = (state == RUN);

`ifdef MOVING_AVERAGE_ROUND_EN
   // Adding half the divisor before the shift gives round-half-up; the extra bit keeps the carry.
   logic [SUM_W:0] rounded;
   assign rounded  = {1'b0, sum} + (SUM_W + 1)'(DEPTH / 2);
   assign out_data = DATA_W'(rounded >> LOG2_DEPTH);
`else
   assign out_data = DATA_W'(sum >> LOG2_DEPTH);
`endif

endmodule

// File: doc/moving_average_filter.md
Name: moving_average_filter

Overview:
- Parametrised sliding-window averager; successor to the fixed-width dynamic adder in the averaging datapath.
- Keeps the last DEPTH unsigned samples in a circular buffer and maintains an exact running sum: one add plus one subtract per accepted sample.
- Emits the sum and its average (sum >> LOG2_DEPTH) behind a valid/ready handshake.
- Sits between a sample source and downstream averaging/reporting logic.

Parameters:
- DATA_W, 8, sample and average width in bits (unsigned), >=2.
- LOG2_DEPTH, 3, log2 of window depth. DEPTH = 2**LOG2_DEPTH, range 1..8.
- SUM_W (localparam), DATA_W+LOG2_DEPTH, running-sum width. This width is overflow-free by construction.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- clear  in  1  synchronous flush of window, sum and output register.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  out_data/out_sum hold a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  window average.
- out_sum  out  SUM_W  window sum.
- window_full  out  1  DEPTH samples have been accepted since reset/clear.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_sum=0, window_full=0.
  - Write pointer=0, fill count=0, state=FILL.
  - Buffer contents are don't-care.
- Handshake rules:
  - in_ready = !out_valid || out_ready (combinational). A sample is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Latency:
  - The result for an accepted sample is registered and visible the next cycle with out_valid=1.
  - Accept and consume in the same cycle sustains 1 sample/cycle.
  - out_data/out_sum stay stable while out_valid=1 && out_ready=0.
  - out_valid falls the cycle after a consume with no new accept.
- State machine:
  - FILL: fill count < DEPTH. On accept: sum += in_data, buf[wp] = in_data, wp++, count++. Go to RUN when count reaches DEPTH; window_full rises in the same register update.
  - RUN: on accept, sum = sum - buf[wp] + in_data; buf[wp] = in_data; wp++. window_full stays 1.
- Pointer and arithmetic:
  - wp is LOG2_DEPTH bits and wraps DEPTH-1 -> 0 naturally.
  - Average = sum >> LOG2_DEPTH (truncating). During FILL the divisor is still DEPTH, so the average ramps up from 0.
  - Subtract-then-add is evaluated at SUM_W bits. The result never goes negative and never exceeds DEPTH*(2**DATA_W-1).
- Boundary cases:
  - clear=1 overrides everything in that cycle: state=FILL, sum=0, count=0, wp=0, out_valid=0, window_full=0. A sample offered in the same cycle is dropped; in_ready may be 1 but the sample is not accepted.
  - Reset mid-window: immediate return to reset values. Partial window discarded.
  - in_valid=1 while in_ready=0: nothing changes; source must hold.
  - DEPTH=1 (LOG2_DEPTH=0): out_data = the last sample; window_full=1 after the first accept.

Optional Feature:
- Macro: MOVING_AVERAGE_ROUND_EN.
- Defined: out_data = (sum + 2**(LOG2_DEPTH-1)) >> LOG2_DEPTH, computed at SUM_W+1 bits. This is round-half-up and never exceeds 2**DATA_W-1. For LOG2_DEPTH=0 the result equals truncation.
- Undefined: truncating shift only; no extra adder.
- out_sum is identical in both builds.

Test Plan:
All scenarios use DATA_W=8, LOG2_DEPTH=3.
- Reset/idle: rst_n=0 for 3 cycles, in_valid=1 -> out_valid=0, out_data=0, out_sum=0, window_full=0. After release, in_ready=1.
- Fill: 8 accepts of 3 with out_ready=1 -> out_sum 3,6,...,24. out_data 0 for sums 3..6, 1 at 9, ..., 3 at 24. window_full=1 with the 8th result.
- Slide and wrap: after the fill, accept 13 then 8 x 255:
  - After 13: out_sum=34, out_data=4.
  - After all 255s: out_sum=2040, out_data=255.
  - wp has wrapped to 1 after the 13 and back to 1 after the eighth 255.
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0, out_data/out_sum frozen for 5 cycles, held input not accepted. Raising out_ready -> held sample accepted that cycle, new result next cycle.
- Clear collision: clear=1 with in_valid=1 mid-RUN (sum=40) -> next cycle out_valid=0, window_full=0. Next accept of 7 gives out_sum=7 (dropped sample not counted).
- Rounding: 4 accepts of 3 (sum=12) -> out_data=1 without MOVING_AVERAGE_ROUND_EN, out_data=2 with it. With the macro defined, 8 x 255 still gives out_data=255.
